// File: rtl/vx_csa_gather_if.sv
// -----------------------------------------------------------------------------
// vx_csa_gather_if
//   Handshake bundle between the operand gatherer and its surroundings.
//   Carries the input beat stream (in_*) and the packed output bundle (out_*).
//
//   Parameters: N operands per group, W operand width, L lanes per beat.
//   CW = $clog2(N+1) is derived and sizes out_count.
//
//   Modports:
//     master : the gather block (drives in_ready and the output bundle)
//     slave  : the environment (drives the beat stream and out_ready)
// -----------------------------------------------------------------------------
interface vx_csa_gather_if #(
  parameter int N = 11,
  parameter int W = 8,
  parameter int L = 4
);
  localparam int CW = $clog2(N + 1);

  logic                  in_valid;
  logic [L-1:0][W-1:0]   in_data;
  logic [L-1:0]          in_mask;
  logic                  in_last;
  logic                  in_ready;

  logic                  out_valid;
  logic [N-1:0][W-1:0]   out_operands;
  logic [CW-1:0]         out_count;
  logic                  out_ready;

  modport master (
    input  in_valid, in_data, in_mask, in_last, out_ready,
    output in_ready, out_valid, out_operands, out_count
  );

  modport slave (
    output in_valid, in_data, in_mask, in_last, out_ready,
    input  in_ready, out_valid, out_operands, out_count
  );
endinterface

// File: rtl/vx_csa_gather.sv
// -----------------------------------------------------------------------------
// vx_csa_gather
//   Operand-gathering stage in front of the mod-4 CSA reduction tree. Beats of
//   L lanes are packed into an N-slot bundle (one reduction group); the full
//   bundle, zero-padded where beats did not reach, is then held for the tree
//   under a valid/ready handshake.
//
//   Ports:
//     clk      clock
//     reset_n  asynchronous active-low reset
//     bus      vx_csa_gather_if.master (in_* beat stream, out_* bundle)
//     perf_groups / perf_stalls  (only with VX_CSA_GATHER_PERF_EN)
//
//   Optional feature macro: VX_CSA_GATHER_PERF_EN
//     Adds 32-bit wrapping counters of bundles handed off and of stall
//     cycles (out_valid && !out_ready).
//
//   Parameters must match those of the connected interface instance.
// -----------------------------------------------------------------------------
module vx_csa_gather #(
  parameter int N = 11,
  parameter int W = 8,
  parameter int L = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  vx_csa_gather_if.master   bus
`ifdef VX_CSA_GATHER_PERF_EN
  ,
  output logic [31:0]       perf_groups,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int BEATS = (N + L - 1) / L;
  localparam int CW    = $clog2(N + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [N-1:0][W-1:0] ops_q, ops_d;
  logic [CW-1:0]       count_q, count_d;
  logic                out_valid_q, out_valid_d;

  logic                in_ready;
  logic                accept;
  logic                handoff;
  int                  k;
  int                  slot;

  // While filling we always take beats; while issuing, a new beat can only
  // enter on the same edge the held bundle leaves.
  assign in_ready = (state_q == ST_FILL) ? 1'b1 : bus.out_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ops_d   = ops_q;
    count_d = count_q;
    slot    = 0;

    accept  = bus.in_valid && in_ready;
    handoff = (state_q == ST_ISSUE) && bus.out_ready;
    // A beat taken during handoff is always the first beat of the next group.
    k       = (state_q == ST_FILL) ? int'(beat_q) : 0;

    if (handoff) begin
      state_d = ST_FILL;
      beat_d  = '0;
    end

    if (accept) begin
      // First beat of a group wipes the previous bundle so that short groups
      // never expose stale operands in their unwritten slots.
      if (k == 0) begin
        ops_d   = '0;
        count_d = '0;
      end
      for (int j = 0; j < L; j++) begin
        slot = k * L + j;
        // Lanes past slot N-1 on the final beat are dropped and not counted.
        if (slot < N) begin
          ops_d[slot] = bus.in_mask[j] ? bus.in_data[j] : '0;
          if (bus.in_mask[j]) count_d = count_d + CW'(1);
        end
      end
      if (bus.in_last || (k == BEATS - 1)) begin
        state_d = ST_ISSUE;
        beat_d  = '0;
      end else begin
        state_d = ST_FILL;
        beat_d  = BW'(k + 1);
      end
    end

    out_valid_d = (state_d == ST_ISSUE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the operand register is reset as a whole because the bundle is a
  // visible output whose reset value is zero, not a scratch memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FILL;
      beat_q      <= '0;
      ops_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      ops_q       <= ops_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_operands = ops_q;
  assign bus.out_count    = count_q;

`ifdef VX_CSA_GATHER_PERF_EN
  logic [31:0] perf_groups_q, perf_groups_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_groups_d = perf_groups_q + (handoff ? 32'd1 : 32'd0);
    perf_stalls_d = perf_stalls_q + ((out_valid_q && !bus.out_ready) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_groups_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_groups_q <= perf_groups_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_groups = perf_groups_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_csa_gather.sv
// -----------------------------------------------------------------------------
// tb_vx_csa_gather
//   Directed bench for vx_csa_gather with N=11, W=8, L=4 (three beats per
//   group). Inputs change 1 time unit after the rising edge; outputs are
//   sampled at that point too, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_vx_csa_gather;

  localparam int N  = 11;
  localparam int W  = 8;
  localparam int L  = 4;

  logic clk;
  logic reset_n;

  vx_csa_gather_if #(.N(N), .W(W), .L(L)) bus ();

`ifdef VX_CSA_GATHER_PERF_EN
  logic [31:0] perf_groups;
  logic [31:0] perf_stalls;
`endif

  vx_csa_gather #(.N(N), .W(W), .L(L)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef VX_CSA_GATHER_PERF_EN
    ,
    .perf_groups (perf_groups),
    .perf_stalls (perf_stalls)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int errors  = 0;

  logic [N-1:0][W-1:0] exp_ops;
  logic [N-1:0][W-1:0] held_ops;

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3,
                       input logic [3:0] m, input logic last);
    bus.in_valid   = 1'b1;
    bus.in_data[0] = d0;
    bus.in_data[1] = d1;
    bus.in_data[2] = d2;
    bus.in_data[3] = d3;
    bus.in_mask    = m;
    bus.in_last    = last;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_mask  = '0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    #2 reset_n = 1'b0;

    // ---- reset state ----
    #1;
    check("rst_in_ready",  bus.in_ready,     1);
    check("rst_out_valid", bus.out_valid,    0);
    check("rst_operands",  bus.out_operands, 0);
    check("rst_count",     bus.out_count,    0);
    tick();
    reset_n = 1'b1;

    // ---- full group: slot s = s+1, lane value 12 dropped ----
    drive(8'd1, 8'd2, 8'd3, 8'd4, 4'hF, 1'b0);
    tick();
    check("full_b0_valid", bus.out_valid, 0);
    drive(8'd5, 8'd6, 8'd7, 8'd8, 4'hF, 1'b0);
    tick();
    check("full_b1_valid", bus.out_valid, 0);
    drive(8'd9, 8'd10, 8'd11, 8'd12, 4'hF, 1'b0);
    tick();
    for (int s = 0; s < N; s++) exp_ops[s] = 8'(s + 1);
    check("full_valid", bus.out_valid,    1);
    check("full_ops",   bus.out_operands, exp_ops);
    check("full_count", bus.out_count,    11);
    idle();
    tick();
    check("full_drain_valid", bus.out_valid, 0);

    // ---- early last with mask: no leak from previous group ----
    drive(8'd7, 8'd7, 8'd7, 8'd7, 4'b0101, 1'b1);
    tick();
    exp_ops    = '0;
    exp_ops[0] = 8'd7;
    exp_ops[2] = 8'd7;
    check("early_valid", bus.out_valid,    1);
    check("early_ops",   bus.out_operands, exp_ops);
    check("early_count", bus.out_count,    2);

    // ---- backpressure: offered beat must not be taken ----
    bus.out_ready = 1'b0;
    drive(8'hAA, 8'hAA, 8'hAA, 8'hAA, 4'hF, 1'b0);
    #1;
    check("bp_in_ready", bus.in_ready, 0);
    held_ops = exp_ops;
    for (int c = 0; c < 5; c++) tick();
    check("bp_valid", bus.out_valid,    1);
    check("bp_ops",   bus.out_operands, held_ops);
    check("bp_count", bus.out_count,    2);
`ifdef VX_CSA_GATHER_PERF_EN
    check("bp_perf_stalls", perf_stalls, 5);
    check("bp_perf_groups_before", perf_groups, 1);
`endif
    idle();
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", bus.in_ready, 1);
    tick();
    check("bp_release_valid", bus.out_valid, 0);
`ifdef VX_CSA_GATHER_PERF_EN
    check("bp_perf_groups_after", perf_groups, 2);
`endif

    // ---- back-to-back: 3 groups, 9 continuous beats, bundles after 3/6/9 ----
    // value = 16*(g+1) + slot; group 1 masks lane 0 of its first beat.
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < 3; b++) begin
        drive(8'(16 * (g + 1) + 4 * b + 0), 8'(16 * (g + 1) + 4 * b + 1),
              8'(16 * (g + 1) + 4 * b + 2), 8'(16 * (g + 1) + 4 * b + 3),
              (g == 1 && b == 0) ? 4'b1110 : 4'b1111, 1'b0);
        #1;
        check($sformatf("b2b_in_ready_g%0d_b%0d", g, b), bus.in_ready, 1);
        tick();
        check($sformatf("b2b_valid_g%0d_b%0d", g, b), bus.out_valid, (b == 2));
      end
      for (int s = 0; s < N; s++) exp_ops[s] = 8'(16 * (g + 1) + s);
      if (g == 1) exp_ops[0] = 8'd0;
      check($sformatf("b2b_ops_g%0d", g),   bus.out_operands, exp_ops);
      check($sformatf("b2b_count_g%0d", g), bus.out_count,    (g == 1) ? 10 : 11);
    end
    idle();
    tick();
    check("b2b_drain_valid", bus.out_valid, 0);

    // ---- reset mid-fill ----
    drive(8'h50, 8'h51, 8'h52, 8'h53, 4'hF, 1'b0);
    tick();
    drive(8'h54, 8'h55, 8'h56, 8'h57, 4'hF, 1'b0);
    tick();
    idle();
    reset_n = 1'b0;
    #2;
    check("midrst_valid", bus.out_valid,    0);
    check("midrst_count", bus.out_count,    0);
    check("midrst_ops",   bus.out_operands, 0);
    tick();
    check("midrst_held_valid", bus.out_valid, 0);
    reset_n = 1'b1;
    for (int b = 0; b < 3; b++) begin
      drive(8'(8'h60 + 4 * b), 8'(8'h61 + 4 * b), 8'(8'h62 + 4 * b),
            8'(8'h63 + 4 * b), 4'hF, 1'b0);
      tick();
    end
    for (int s = 0; s < N; s++) exp_ops[s] = 8'(8'h60 + s);
    check("postrst_valid", bus.out_valid,    1);
    check("postrst_ops",   bus.out_operands, exp_ops);
    check("postrst_count", bus.out_count,    11);

    // ---- empty last taken during handoff: ISSUE -> ISSUE ----
    drive(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b0000, 1'b1);
    tick();
    check("empty_valid", bus.out_valid,    1);
    check("empty_ops",   bus.out_operands, 0);
    check("empty_count", bus.out_count,    0);

    // ---- short group taken during handoff ----
    drive(8'd3, 8'd3, 8'd3, 8'd3, 4'b0011, 1'b1);
    tick();
    exp_ops    = '0;
    exp_ops[0] = 8'd3;
    exp_ops[1] = 8'd3;
    check("short_valid", bus.out_valid,    1);
    check("short_ops",   bus.out_operands, exp_ops);
    check("short_count", bus.out_count,    2);

    // ---- all-masked last beat keeps count of earlier beats ----
    drive(8'd1, 8'd2, 8'd3, 8'd4, 4'hF, 1'b0);
    tick();
    check("masklast_b0_valid", bus.out_valid, 0);
    drive(8'hEE, 8'hEE, 8'hEE, 8'hEE, 4'b0000, 1'b1);
    tick();
    exp_ops = '0;
    for (int s = 0; s < 4; s++) exp_ops[s] = 8'(s + 1);
    check("masklast_valid", bus.out_valid,    1);
    check("masklast_ops",   bus.out_operands, exp_ops);
    check("masklast_count", bus.out_count,    4);
    idle();
    tick();
    check("final_drain_valid", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
